// File: rtl/mod_multiport_register_file_pkg.sv
// Shared defaults and dump-engine state encoding for the multiport register file.
package mod_multiport_register_file_pkg;

  localparam int unsigned DataWDefault   = 32;
  localparam int unsigned NumRegsDefault = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDone   = 2'd2
  } dump_state_e;

endpackage

// File: rtl/mod_regfile_dump_fsm.sv
// Dump engine: walks register indices 1..NUM_REGS-1 over a valid/ready channel.
module mod_regfile_dump_fsm
  import mod_multiport_register_file_pkg::*;
#(
  parameter int unsigned NUM_REGS = NumRegsDefault,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d = StStream;
          index_d = ADDR_W'(1);
        end
      end
      StStream: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (index_q == LastIdx) begin
            state_d = StDone;
          end else begin
            index_d = index_q + ADDR_W'(1);
          end
        end
      end
      StDone: begin
        dump_done = 1'b1;
        state_d   = StIdle;
        index_d   = '0;
      end
      default: begin
        state_d = StIdle;
        index_d = '0;
      end
    endcase
  end

  assign dump_index = index_q;
  assign dump_busy  = (state_q != StIdle);

endmodule

// File: rtl/mod_multiport_register_file.sv
// Register file with r0 hardwired to zero, NUM_RD combinational reads, two prioritised
// write ports, optional write-to-read bypass and a streaming dump engine.
module mod_multiport_register_file
  import mod_multiport_register_file_pkg::*;
#(
  parameter  int unsigned DATA_W   = DataWDefault,
  parameter  int unsigned NUM_REGS = NumRegsDefault,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     write_0,
  input  logic [ADDR_W-1:0]        write_address_0,
  input  logic [DATA_W-1:0]        write_data_0,
  input  logic                     write_1,
  input  logic [ADDR_W-1:0]        write_address_1,
  input  logic [DATA_W-1:0]        write_data_1,
  input  logic [NUM_RD*ADDR_W-1:0] read_address,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  input  logic                     dump_start,
  input  logic                     dump_ready,
  output logic                     dump_valid,
  output logic [ADDR_W-1:0]        dump_index,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              we_0, we_1;

  // Index 0 and indices beyond the array are never stored to nor read from.
  function automatic logic live_idx(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  // A running dump blocks writes so the streamed beats stay stable.
  assign we_0 = write_0 & ~hold & ~dump_busy;
  assign we_1 = write_1 & ~hold & ~dump_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (we_0 && live_idx(write_address_0)) regs_q[write_address_0] <= write_data_0;
      // Port 1 is assigned last so it wins a same-index collision.
      if (we_1 && live_idx(write_address_1)) regs_q[write_address_1] <= write_data_1;
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = read_address[k*ADDR_W +: ADDR_W];

    always_comb begin
      rv = '0;
      if (live_idx(ra)) begin
        rv = regs_q[ra];
        if (BYPASS != 0) begin
          if (we_1 && (write_address_1 == ra)) begin
            rv = write_data_1;
          end else if (we_0 && (write_address_0 == ra)) begin
            rv = write_data_0;
          end
        end
      end
    end

    assign read_data[k*DATA_W +: DATA_W] = rv;
  end

  mod_regfile_dump_fsm #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_dump_fsm (
    .clk       (clk),
    .reset     (reset),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_index(dump_index),
    .dump_busy (dump_busy),
    .dump_done (dump_done)
  );

  assign dump_data = regs_q[dump_index];

endmodule

// File: tb/tb_mod_multiport_register_file.sv
// Scoreboard bench for mod_multiport_register_file: reads, collisions, hold and dump streaming.
module tb_mod_multiport_register_file;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hold = 1'b0;
  logic              write_0 = 1'b0;
  logic [AW-1:0]     write_address_0 = '0;
  logic [DW-1:0]     write_data_0 = '0;
  logic              write_1 = 1'b0;
  logic [AW-1:0]     write_address_1 = '0;
  logic [DW-1:0]     write_data_1 = '0;
  logic [NRD*AW-1:0] read_address = '0;
  logic [NRD*DW-1:0] read_data;
  logic              dump_start = 1'b0;
  logic              dump_ready = 1'b0;
  logic              dump_valid;
  logic [AW-1:0]     dump_index;
  logic [DW-1:0]     dump_data;
  logic              dump_busy;
  logic              dump_done;

  always #5 clk = ~clk;

  mod_multiport_register_file #(
    .DATA_W  (DW),
    .NUM_REGS(NR),
    .NUM_RD  (NRD),
    .BYPASS  (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .write_0        (write_0),
    .write_address_0(write_address_0),
    .write_data_0   (write_data_0),
    .write_1        (write_1),
    .write_address_1(write_address_1),
    .write_data_1   (write_data_1),
    .read_address   (read_address),
    .read_data      (read_data),
    .dump_start     (dump_start),
    .dump_ready     (dump_ready),
    .dump_valid     (dump_valid),
    .dump_index     (dump_index),
    .dump_data      (dump_data),
    .dump_busy      (dump_busy),
    .dump_done      (dump_done)
  );

  typedef struct {
    string       tag;
    int          port;
    logic [63:0] val;
  } rd_exp_t;

  rd_exp_t     rq[$];
  logic [63:0] bq[$];
  logic [DW-1:0] model [NR];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int port, input int addr, input logic [63:0] exp, input string tag);
    read_address[port*AW +: AW] = AW'(addr);
    rq.push_back('{tag: tag, port: port, val: exp});
  endtask

  task automatic check_reads();
    rd_exp_t e;
    #1;
    while (rq.size() > 0) begin
      e = rq.pop_front();
      check(e.tag, 64'(read_data[e.port*DW +: DW]), e.val);
    end
  endtask

  task automatic clear_writes();
    write_0 = 1'b0;
    write_1 = 1'b0;
    hold    = 1'b0;
  endtask

  // Streams a full dump; toggle drops ready every other cycle, abort_idx>0 resets at that beat.
  task automatic run_dump(input bit toggle, input int abort_idx, input string tag);
    int cycles;
    logic [63:0] b;
    bit aborted;
    aborted = 1'b0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 1; i < NR; i++) bq.push_back(64'({AW'(i), model[i]}));
    cycles = 0;
    while (bq.size() > 0 && cycles < 200) begin
      dump_ready = toggle ? cycles[0] : 1'b1;
      if (toggle && cycles == 5) begin
        write_0 = 1'b1;
        write_address_0 = AW'(9);
        write_data_0 = 32'hFF;
      end else begin
        write_0 = 1'b0;
      end
      #1;
      if (!dump_valid) begin
        check({tag, "_valid"}, 64'(dump_valid), 64'(1));
      end else if (abort_idx > 0 && bq[0][63:32] == 32'(abort_idx)) begin
        reset = 1'b1;
        aborted = 1'b1;
        tick();
        reset = 1'b0;
        bq.delete();
        break;
      end else if (dump_ready) begin
        b = bq.pop_front();
        check({tag, "_beat"}, 64'({dump_index, dump_data}), b);
      end else begin
        check({tag, "_stall"}, 64'({dump_index, dump_data}), bq[0]);
      end
      tick();
      cycles++;
    end
    write_0 = 1'b0;
    dump_ready = 1'b0;
    check({tag, "_timeout"}, 64'(bq.size()), 64'(0));
    bq.delete();
    if (aborted) begin
      #1;
      check({tag, "_abort_valid"}, 64'(dump_valid), 64'(0));
      check({tag, "_abort_busy"}, 64'(dump_busy), 64'(0));
      check({tag, "_abort_done"}, 64'(dump_done), 64'(0));
      for (int i = 0; i < NR; i++) model[i] = '0;
      tick();
      check({tag, "_abort_done2"}, 64'(dump_done), 64'(0));
    end else begin
      if (!toggle) check({tag, "_cycles"}, 64'(cycles), 64'(NR - 1));
      #1;
      check({tag, "_done"}, 64'(dump_done), 64'(1));
      check({tag, "_busy_in_done"}, 64'(dump_busy), 64'(1));
      tick();
      check({tag, "_done_low"}, 64'(dump_done), 64'(0));
      check({tag, "_busy_low"}, 64'(dump_busy), 64'(0));
      check({tag, "_idx_zero"}, 64'(dump_index), 64'(0));
    end
  endtask

  task automatic load_index_values();
    for (int i = 1; i < NR; i += 2) begin
      write_0 = 1'b1;
      write_address_0 = AW'(i);
      write_data_0 = DW'(i);
      write_1 = (i + 1 < NR);
      write_address_1 = AW'(i + 1);
      write_data_1 = DW'(i + 1);
      tick();
    end
    clear_writes();
    for (int i = 1; i < NR; i++) model[i] = DW'(i);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    tick();
    tick();
    check("rst_valid", 64'(dump_valid), 64'(0));
    check("rst_busy", 64'(dump_busy), 64'(0));
    check("rst_done", 64'(dump_done), 64'(0));
    check("rst_index", 64'(dump_index), 64'(0));
    reset = 1'b0;
    rd(0, 5, 64'(0), "rst_r5");
    rd(1, 31, 64'(0), "rst_r31");
    check_reads();

    // Basic write then read next cycle; r0 stays zero even with bypass.
    write_0 = 1'b1; write_address_0 = 5'd5; write_data_0 = 32'hDEADBEEF;
    tick();
    write_0 = 1'b1; write_address_0 = 5'd0; write_data_0 = 32'h1234;
    rd(0, 5, 64'hDEADBEEF, "r5_after_write");
    rd(1, 0, 64'(0), "r0_bypass");
    check_reads();
    tick();
    clear_writes();
    rd(0, 0, 64'(0), "r0_stored");
    check_reads();

    // Collision on r7: port 1 wins, including the bypassed read.
    write_0 = 1'b1; write_address_0 = 5'd7; write_data_0 = 32'h11;
    write_1 = 1'b1; write_address_1 = 5'd7; write_data_1 = 32'h22;
    rd(0, 7, 64'h22, "r7_bypass");
    rd(1, 8, 64'(0), "r8_untouched");
    check_reads();
    tick();
    clear_writes();
    rd(0, 7, 64'h22, "r7_stored");
    check_reads();

    // Port 0 bypass alone.
    write_0 = 1'b1; write_address_0 = 5'd4; write_data_0 = 32'hAB;
    rd(1, 4, 64'hAB, "r4_bypass_p0");
    check_reads();
    tick();
    clear_writes();

    // Hold blocks both storage and bypass.
    hold = 1'b1;
    write_0 = 1'b1; write_address_0 = 5'd3; write_data_0 = 32'h55;
    write_1 = 1'b1; write_address_1 = 5'd6; write_data_1 = 32'h66;
    rd(0, 3, 64'(0), "r3_hold_bypass");
    rd(1, 6, 64'(0), "r6_hold_bypass");
    check_reads();
    tick();
    clear_writes();
    rd(0, 3, 64'(0), "r3_hold_stored");
    rd(1, 6, 64'(0), "r6_hold_stored");
    check_reads();

    load_index_values();
    rd(0, 1, 64'(1), "load_r1");
    rd(1, 31, 64'(31), "load_r31");
    check_reads();

    run_dump(1'b0, 0, "dump_full");
    run_dump(1'b1, 0, "dump_toggle");
    rd(0, 9, 64'(9), "r9_blocked_write");
    check_reads();

    run_dump(1'b0, 10, "dump_abort");
    for (int i = 1; i < NR; i += 2) begin
      rd(0, i, 64'(model[i]), "abort_clear_a");
      if (i + 1 < NR) rd(1, i + 1, 64'(model[i + 1]), "abort_clear_b");
      check_reads();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_multiport_register_file.md
Name: mod_multiport_register_file

Overview:
Parametrised successor to the single-write architectural register file. It provides DATA_W x NUM_REGS storage with register 0 hardwired to zero, NUM_RD combinational read ports, and two prioritised write ports. Optional write-to-read bypass is selected by a parameter. A hardware dump engine streams every register, with its index, over a valid/ready channel, so end-of-test architectural state can be taken without simulation-only file writes. It sits in the decode stage, between writeback and operand fetch.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers including hardwired r0; must be >= 2
ADDR_W, $clog2(NUM_REGS), register index width; derived, not overridden
NUM_RD, 2, number of read ports; must be >= 1
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored value only

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
hold  in  1  pipeline stall; blocks both write ports
write_0  in  1  write enable, port 0
write_address_0  in  ADDR_W  destination index, port 0
write_data_0  in  DATA_W  write data, port 0
write_1  in  1  write enable, port 1 (higher priority)
write_address_1  in  ADDR_W  destination index, port 1
write_data_1  in  DATA_W  write data, port 1
read_address  in  NUM_RD*ADDR_W  packed read indices; port k at [k*ADDR_W +: ADDR_W]
read_data  out  NUM_RD*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W]
dump_start  in  1  request a full register dump
dump_ready  in  1  consumer accepts the current dump beat
dump_valid  out  1  dump beat valid
dump_index  out  ADDR_W  register index of the current beat
dump_data  out  DATA_W  register value of the current beat
dump_busy  out  1  dump engine is not in IDLE
dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (sync, active-high): registers 1..NUM_REGS-1 are set to 0; FSM goes to IDLE; dump_valid, dump_busy and dump_done are 0; dump_index is 0. Reset overrides all other inputs in the same cycle.
- Effective write enable: we_k = write_k & ~hold & ~dump_busy. A write to index 0 is discarded. Storage updates at the clock edge.
- Collision: if both ports write the same nonzero index in the same cycle, port 1 wins.
- Read: combinational. Index 0 returns 0. An index >= NUM_REGS returns 0.
- Bypass (BYPASS=1): if we_1 is set and the addresses match, read port k returns write_data_1. Otherwise, if we_0 is set and the addresses match, it returns write_data_0. Otherwise it returns stored data. Index 0 is never bypassed. With BYPASS=0, a read returns the new value from the cycle after the write.
- Dump FSM, states IDLE, STREAM, DONE:
  - IDLE: when dump_start=1, go to STREAM and set dump_index=1. The first beat is valid the cycle after dump_start.
  - STREAM: dump_valid=1; dump_data = reg[dump_index]. On dump_valid & dump_ready: if dump_index == NUM_REGS-1, go to DONE; otherwise increment dump_index. While ready is low, the beat stays stable, because writes are blocked during a dump.
  - DONE: dump_done=1 for one cycle, then return to IDLE with dump_index=0.
  - dump_start outside IDLE is ignored. Register 0 is never dumped.
- dump_busy = (state != IDLE). The pipeline must treat dump_busy like hold. Writes attempted while busy are lost; the block does not queue them.
- Reset during STREAM or DONE aborts the dump: the next cycle is IDLE, with no dump_done pulse.

Decomposition:
- Shared core package: DATA_W and NUM_REGS defaults, and the dump FSM state enum (IDLE=2'd0, STREAM=2'd1, DONE=2'd2).
- One natural sub-module: mod_regfile_dump_fsm. It holds the state, the index counter, the handshake logic and dump_done. The storage array and bypass logic stay in the top.

Test Plan:
- Reset, write r5=0xDEADBEEF via port 0, read r5 next cycle -> 0xDEADBEEF; write r0=0x1234 -> read r0 returns 0.
- Same cycle, port 0 r7=0x11 and port 1 r7=0x22 -> r7=0x22. With BYPASS=1, a same-cycle read of r7 also returns 0x22.
- hold=1 while writing r3=0x55 -> r3 stays 0. A read of r3 in that cycle returns 0, with no bypass.
- Load r1..r31 with value=index, pulse dump_start, dump_ready=1 -> 31 consecutive beats (index 1..31, data 1..31), then dump_done high one cycle, dump_busy low the cycle after.
- Same dump with dump_ready toggling every other cycle -> each beat is held stable until accepted. A write to r9=0xFF issued during the dump does not change r9.
- Reset asserted at beat index 10 -> next cycle dump_valid=0, dump_busy=0, all registers 0, no dump_done pulse.
